// File: rtl/or1k_wb32_slave_mem.sv
// or1k_wb32_slave_mem
// Wishbone B3 32-bit slave in front of a single-port synchronous RAM with one
// cycle of read latency. Classic cycles always work. Define
// OR1K_WB_SLAVE_BURST_EN to compile in incrementing linear/wrap bursts at one
// beat per cycle. Without it, every access is classic: one ack, then one dead cycle.
module or1k_wb32_slave_mem #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic                  wbs_we_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [2:0]            wbs_cti_i,
  input  logic [1:0]            wbs_bte_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [ADDR_WIDTH-1:0] mem_adr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_sel_o,
  output logic [31:0]           mem_dat_o,
  input  logic [31:0]           mem_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLASSIC = 2'd1,
    S_BURST   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_ack;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_baddr;

  logic                  w_req;
  logic                  w_in_range;
  logic                  w_go_burst;
  logic [ADDR_WIDTH-1:0] w_adr_word;
  logic                  w_unused;

  assign w_req      = wbs_cyc_i & wbs_stb_i;
  assign w_in_range = (wbs_adr_i[31:ADDR_WIDTH+2] == '0);
  assign w_adr_word = wbs_adr_i[ADDR_WIDTH+1:2];
  // Byte-lane address bits are meaningless on a 32-bit word bus; burst
  // controls are dead inputs when bursts are compiled out.
  assign w_unused   = ^{wbs_adr_i[1:0], wbs_cti_i, wbs_bte_i};

  // Data and byte lanes pass straight through between bus and memory.
  assign wbs_dat_o = mem_dat_i;
  assign mem_dat_o = wbs_dat_i;
  assign mem_sel_o = wbs_sel_i;
  assign wbs_rty_o = 1'b0;
  assign wbs_err_o = r_err;

`ifdef OR1K_WB_SLAVE_BURST_EN
  logic                  w_beat;
  logic                  w_eob;
  logic [ADDR_WIDTH-1:0] w_next;

  // Next beat address: linear wraps the whole space, wrapN only the low bits.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [1:0]            bte
  );
    logic [ADDR_WIDTH-1:0] n;
    n = a;
    case (bte)
      2'b00:   n      = a + ADDR_WIDTH'(1);
      2'b01:   n[1:0] = a[1:0] + 2'd1;
      2'b10:   n[2:0] = a[2:0] + 3'd1;
      default: n[3:0] = a[3:0] + 4'd1;
    endcase
    return n;
  endfunction

  // A burst beat is served only while the master still requests the address
  // we prefetched; anything else ends the burst without an ack.
  assign w_beat     = (r_state == S_BURST) & w_req & (w_adr_word == r_baddr);
  assign w_eob      = (wbs_cti_i == 3'b111);
  assign w_next     = f_next_addr(r_baddr, wbs_bte_i);
  assign w_go_burst = (wbs_cti_i == 3'b010);
  // Ack is registered, but inside a burst it is withheld on a stalled or
  // mismatched beat so the master never sees an ack for the wrong address.
  assign wbs_ack_o  = r_ack & ((r_state != S_BURST) | w_beat);
`else
  assign w_go_burst = 1'b0;
  assign wbs_ack_o  = r_ack;
`endif

  // Memory strobes and address: read issued on request, write on the ack beat.
  always_comb begin
    mem_re_o  = 1'b0;
    mem_we_o  = 1'b0;
    mem_adr_o = r_baddr;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_in_range) begin
            mem_adr_o = w_adr_word;
            mem_re_o  = ~wbs_we_i;
          end
        end
        S_CLASSIC: begin
          mem_we_o = r_ack & wbs_we_i & wbs_stb_i;
        end
`ifdef OR1K_WB_SLAVE_BURST_EN
        S_BURST: begin
          if (w_beat) begin
            if (wbs_we_i) begin
              mem_we_o = 1'b1;
            end else if (!w_eob) begin
              mem_re_o  = 1'b1;
              mem_adr_o = w_next;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Cycle state machine with registered ack/err and the beat address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_baddr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (w_req) begin
            if (!w_in_range) begin
              r_err   <= 1'b1;
              r_state <= S_CLASSIC;
            end else begin
              r_baddr <= w_adr_word;
              r_ack   <= 1'b1;
              r_state <= w_go_burst ? S_BURST : S_CLASSIC;
            end
          end
        end
`ifdef OR1K_WB_SLAVE_BURST_EN
        S_BURST: begin
          if (w_beat) begin
            r_baddr <= w_next;
            if (w_eob) begin
              r_state <= S_IDLE;
              r_ack   <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_or1k_wb32_slave_mem.sv
// Testbench for or1k_wb32_slave_mem: directed Wishbone cycles against a
// behavioural synchronous RAM. Burst expectations follow OR1K_WB_SLAVE_BURST_EN.
module tb_or1k_wb32_slave_mem;
  localparam int AW = 14;
`ifdef OR1K_WB_SLAVE_BURST_EN
  localparam int WSEQ [8] = '{7, 0, 1, 2, 3, 4, 5, 6};
`endif

  logic          clk;
  logic          rst;
  logic [31:0]   wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [3:0]    wbs_sel_i;
  logic          wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [2:0]    wbs_cti_i;
  logic [1:0]    wbs_bte_i;
  logic          wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [AW-1:0] mem_adr_o;
  logic          mem_re_o, mem_we_o;
  logic [3:0]    mem_sel_o;
  logic [31:0]   mem_dat_o;
  logic [31:0]   mem_dat_i;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   rd_q;
  logic          pl_en;
  logic [AW-1:0] pl_adr;
  logic [31:0]   pl_dat;
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_re = 0;
  int            n_we = 0;

  or1k_wb32_slave_mem #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_rty_o(wbs_rty_o),
    .mem_adr_o(mem_adr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dat_i = rd_q;

  // Synchronous RAM with one cycle read latency, byte writes and a preload port.
  always @(posedge clk) begin
    if (mem_re_o) rd_q <= mem[mem_adr_o];
    if (pl_en) mem[pl_adr] = pl_dat;
    if (mem_we_o)
      for (int b = 0; b < 4; b++)
        if (mem_sel_o[b]) mem[mem_adr_o][8*b +: 8] = mem_dat_o[8*b +: 8];
    n_re += int'(mem_re_o);
    n_we += int'(mem_we_o);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic pload(input int a, input logic [31:0] d);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_adr = AW'(a);
    pl_dat = d;
  endtask

  // Present one cycle of bus inputs at the falling edge, settle, then check.
  task automatic drv(input logic cyc, input logic stb, input logic we,
                     input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    @(negedge clk);
    wbs_cyc_i = cyc; wbs_stb_i = stb; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    wbs_cti_i = cti; wbs_bte_i = bte;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int b;
    rst = 1'b1; pl_en = 1'b0; pl_adr = '0; pl_dat = '0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h100;
    wbs_dat_i = 32'h0; wbs_sel_i = 4'hF; wbs_cti_i = 3'b000; wbs_bte_i = 2'b00;
    @(negedge clk); #1;
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_err", 32'(wbs_err_o), 32'd0);
    chk("rst_rty", 32'(wbs_rty_o), 32'd0);
    chk("rst_re",  32'(mem_re_o),  32'd0);
    chk("rst_we",  32'(mem_we_o),  32'd0);

    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    pload(32'h40, 32'hDEADBEEF);
    pload(32'h41, 32'hFFFFFFFF);
    for (int i = 0; i < 16; i++) pload(i, 32'hA000_0000 | 32'(i));
    for (int i = 0; i < 8; i++) pload(32'h80 + i, 32'hB000_0000 | 32'(i));
    pload(32'h90, 32'h0);
    pload(32'h91, 32'h0);
    @(negedge clk);
    pl_en = 1'b0;
    rst = 1'b0;

    // Classic read of word 0x40
    drv(1, 1, 0, 32'h100, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("crd_re", 32'(mem_re_o), 32'd1);
    chk("crd_adr", 32'(mem_adr_o), 32'h40);
    chk("crd_ack_n", 32'(wbs_ack_o), 32'd0);
    drv(1, 1, 0, 32'h100, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("crd_ack", 32'(wbs_ack_o), 32'd1);
    chk("crd_dat", wbs_dat_o, 32'hDEADBEEF);
    chk("crd_err", 32'(wbs_err_o), 32'd0);
    idle();
    chk("crd_ack_n2", 32'(wbs_ack_o), 32'd0);

    // Classic write, low two bytes only
    drv(1, 1, 1, 32'h104, 32'h12345678, 4'b0011, 3'b000, 2'b00);
    chk("cwr_we_n", 32'(mem_we_o), 32'd0);
    drv(1, 1, 1, 32'h104, 32'h12345678, 4'b0011, 3'b000, 2'b00);
    chk("cwr_ack", 32'(wbs_ack_o), 32'd1);
    chk("cwr_we", 32'(mem_we_o), 32'd1);
    chk("cwr_adr", 32'(mem_adr_o), 32'h41);
    idle();
    chk("cwr_mem", mem[32'h41], 32'hFFFF5678);

    // Back-to-back classic reads: one dead cycle between them
    drv(1, 1, 0, 32'h100, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("b2b_ack0", 32'(wbs_ack_o), 32'd0);
    drv(1, 1, 0, 32'h100, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("b2b_ack1", 32'(wbs_ack_o), 32'd1);
    chk("b2b_dat1", wbs_dat_o, 32'hDEADBEEF);
    drv(1, 1, 0, 32'h104, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("b2b_dead", 32'(wbs_ack_o), 32'd0);
    drv(1, 1, 0, 32'h104, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("b2b_ack2", 32'(wbs_ack_o), 32'd1);
    chk("b2b_dat2", wbs_dat_o, 32'hFFFF5678);
    idle();

    // Out-of-range read gets err, no ack, no memory strobe
    s = n_re;
    drv(1, 1, 0, 32'h0001_0000, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("oor_re", 32'(mem_re_o), 32'd0);
    drv(1, 1, 0, 32'h0001_0000, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("oor_err", 32'(wbs_err_o), 32'd1);
    chk("oor_ack", 32'(wbs_ack_o), 32'd0);
    idle();
    chk("oor_err_n", 32'(wbs_err_o), 32'd0);
    chk("oor_nre", 32'(n_re - s), 32'd0);

`ifdef OR1K_WB_SLAVE_BURST_EN
    // Wrap8 read burst starting at word 7
    drv(1, 1, 0, 32'h1C, 32'h0, 4'hF, 3'b010, 2'b10);
    chk("w8_ack_n", 32'(wbs_ack_o), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drv(1, 1, 0, 32'(WSEQ[k] * 4), 32'h0, 4'hF, (k == 7) ? 3'b111 : 3'b010, 2'b10);
      chk($sformatf("w8_ack%0d", k), 32'(wbs_ack_o), 32'd1);
      chk($sformatf("w8_dat%0d", k), wbs_dat_o, 32'hA000_0000 | 32'(WSEQ[k]));
    end
    idle();
    chk("w8_end", 32'(wbs_ack_o), 32'd0);

    // Linear burst with a two-cycle strobe gap after the third beat
    drv(1, 1, 0, 32'h200, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("gap_ack_n", 32'(wbs_ack_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drv(1, 1, 0, 32'h200 + 32'(k * 4), 32'h0, 4'hF, 3'b010, 2'b00);
      chk($sformatf("gap_ack%0d", k), 32'(wbs_ack_o), 32'd1);
      chk($sformatf("gap_dat%0d", k), wbs_dat_o, 32'hB000_0000 | 32'(k));
    end
    drv(1, 0, 0, 32'h20C, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("gap_stall1", 32'(wbs_ack_o), 32'd0);
    drv(1, 0, 0, 32'h20C, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("gap_stall2", 32'(wbs_ack_o), 32'd0);
    drv(1, 1, 0, 32'h20C, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("gap_resume", 32'(wbs_ack_o), 32'd0);
    drv(1, 1, 0, 32'h20C, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("gap_ack3", 32'(wbs_ack_o), 32'd1);
    chk("gap_dat3", wbs_dat_o, 32'hB000_0003);
    drv(1, 1, 0, 32'h210, 32'h0, 4'hF, 3'b111, 2'b00);
    chk("gap_ack4", 32'(wbs_ack_o), 32'd1);
    chk("gap_dat4", wbs_dat_o, 32'hB000_0004);
    idle();
    chk("gap_end", 32'(wbs_ack_o), 32'd0);
`else
    // Burst request is served classically: acks on odd cycles only
    b = 0;
    for (int c = 0; c < 8; c++) begin
      drv(1, 1, 0, 32'h200 + 32'(b * 4), 32'h0, 4'hF, (b == 3) ? 3'b111 : 3'b010, 2'b00);
      chk($sformatf("nb_ack_c%0d", c), 32'(wbs_ack_o), (c % 2 == 1) ? 32'd1 : 32'd0);
      if (c % 2 == 1) begin
        chk($sformatf("nb_dat%0d", b), wbs_dat_o, 32'hB000_0000 | 32'(b));
        b++;
      end
    end
    idle();
    chk("nb_end", 32'(wbs_ack_o), 32'd0);
`endif

    // Reset pulsed in the middle of a write burst
    s = n_we;
    drv(1, 1, 1, 32'h240, 32'h1111_0000, 4'hF, 3'b010, 2'b00);
    chk("rb_ack_n", 32'(wbs_ack_o), 32'd0);
    drv(1, 1, 1, 32'h240, 32'h1111_0000, 4'hF, 3'b010, 2'b00);
    chk("rb_ack1", 32'(wbs_ack_o), 32'd1);
    drv(1, 1, 1, 32'h244, 32'h2222_0000, 4'hF, 3'b010, 2'b00);
`ifdef OR1K_WB_SLAVE_BURST_EN
    chk("rb_ack2", 32'(wbs_ack_o), 32'd1);
`else
    chk("rb_ack2", 32'(wbs_ack_o), 32'd0);
`endif
    rst = 1'b1;
    #1;
    chk("rb_rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rb_rst_we", 32'(mem_we_o), 32'd0);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rb_nwe", 32'(n_we - s), 32'd1);
    chk("rb_mem0", mem[32'h90], 32'h1111_0000);
    chk("rb_mem1", mem[32'h91], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
